miner_core_ctrl: RTL and testbench

//  Sequences one SHA-256 miner core over a nonce range. For each nonce it inserts the nonce

---
 rtl/miner_core_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_miner_core_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_core_ctrl.sv
// miner_core_ctrl: walks one SHA-256 miner core over an inclusive (wrapping)
// nonce range. Each nonce is spliced into the job chunk at bits [96:127],
// the message schedule is loaded and waited out, the compressor is started,
// and the returned digest is compared against the job target.
//
// Handshake: a job is taken on a clock edge where job_valid && job_ready and
// abort is low; job_ready is high only in IDLE, so job_valid is ignored while
// busy. comp_done/comp_hash are only looked at while in COMP.
//
// Optional feature: define MINER_CTRL_STATS_EN to add the hash_count output
// (saturating count of CHECK cycles, cleared by rst and job acceptance).
module miner_core_ctrl #(
    parameter int MSA_CYCLES = 48,
    parameter int NONCE_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [0:511]       job_chunk,
    input  logic [NONCE_W-1:0] job_nonce_lo,
    input  logic [NONCE_W-1:0] job_nonce_hi,
    input  logic [0:255]       job_target,
    input  logic               abort,
    output logic               msa_en,
    output logic [0:511]       msa_chunk,
    output logic               comp_start,
    input  logic               comp_done,
    input  logic [0:255]       comp_hash,
    output logic               busy,
    output logic               found_valid,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted
`ifdef MINER_CTRL_STATS_EN
    ,
    output logic [31:0]        hash_count
`endif
);

    localparam int NONCE_OFS = 96;
    localparam int CNT_W     = (MSA_CYCLES > 1) ? $clog2(MSA_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCHED,
        S_COMP,
        S_CHECK
    } state_e;

    state_e             state_q, state_d;
    logic [0:511]       chunk_q, chunk_d;   // job chunk with current nonce spliced in
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] hi_q, hi_d;
    logic [0:255]       target_q, target_d;
    logic [0:255]       hash_q, hash_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               comp_first_q, comp_first_d;
    logic               found_valid_q, found_valid_d;
    logic               exhausted_q, exhausted_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;

    logic               job_accept;
    logic               hash_below;
    logic [NONCE_W-1:0] nonce_inc;

    assign job_accept = (state_q == S_IDLE) && job_valid && !abort;
    assign hash_below = (hash_q < target_q);
    assign nonce_inc  = nonce_q + NONCE_W'(1);

    // Next-state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d       = state_q;
        chunk_d       = chunk_q;
        nonce_d       = nonce_q;
        hi_d          = hi_q;
        target_d      = target_q;
        hash_d        = hash_q;
        cnt_d         = cnt_q;
        comp_first_d  = 1'b0;
        found_valid_d = 1'b0;
        exhausted_d   = 1'b0;
        found_nonce_d = found_nonce_q;

        unique case (state_q)
            S_IDLE: begin
                if (job_accept) begin
                    chunk_d                         = job_chunk;
                    chunk_d[NONCE_OFS +: NONCE_W]   = job_nonce_lo;
                    nonce_d                         = job_nonce_lo;
                    hi_d                            = job_nonce_hi;
                    target_d                        = job_target;
                    found_nonce_d                   = '0;
                    state_d                         = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = CNT_W'(MSA_CYCLES - 1);
                state_d = S_SCHED;
            end
            S_SCHED: begin
                if (cnt_q == '0) begin
                    comp_first_d = 1'b1;
                    state_d      = S_COMP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_COMP: begin
                if (comp_done) begin
                    hash_d  = comp_hash;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hash_below) begin
                    found_nonce_d = nonce_q;
                    found_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (nonce_q == hi_q) begin
                    exhausted_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    nonce_d                       = nonce_inc;
                    chunk_d[NONCE_OFS +: NONCE_W] = nonce_inc;
                    state_d                       = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            comp_first_d  = 1'b0;
            found_valid_d = 1'b0;
            exhausted_d   = 1'b0;
            found_nonce_d = found_nonce_q;
        end
    end

    // State and job registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            chunk_q       <= '0;
            nonce_q       <= '0;
            hi_q          <= '0;
            target_q      <= '0;
            hash_q        <= '0;
            cnt_q         <= '0;
            comp_first_q  <= 1'b0;
            found_valid_q <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
        end else begin
            state_q       <= state_d;
            chunk_q       <= chunk_d;
            nonce_q       <= nonce_d;
            hi_q          <= hi_d;
            target_q      <= target_d;
            hash_q        <= hash_d;
            cnt_q         <= cnt_d;
            comp_first_q  <= comp_first_d;
            found_valid_q <= found_valid_d;
            exhausted_q   <= exhausted_d;
            found_nonce_q <= found_nonce_d;
        end
    end

    assign job_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign msa_en      = (state_q == S_LOAD);
    assign comp_start  = (state_q == S_COMP) && comp_first_q;
    assign msa_chunk   = chunk_q;
    assign found_valid = found_valid_q;
    assign exhausted   = exhausted_q;
    assign found_nonce = found_nonce_q;

`ifdef MINER_CTRL_STATS_EN
    logic [31:0] count_q, count_d;

    // Saturating count of CHECK cycles; a new job restarts it, abort leaves it alone.
    always_comb begin
        count_d = count_q;
        if (job_accept) begin
            count_d = '0;
        end else if ((state_q == S_CHECK) && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Statistics register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hash_count = count_q;
`endif

endmodule

// File: tb/tb_miner_core_ctrl.sv
// Bench for miner_core_ctrl: table of nonce-range jobs driven against a
// compressor model (fixed latency, hash chosen per nonce), scoreboard of
// expected msa nonces and job results, plus hand sequences for reset in
// COMP and abort colliding with comp_done.
module tb_miner_core_ctrl;

  localparam int MSA = 48;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [0:511] job_chunk = '0;
  logic [31:0]  job_nonce_lo = '0;
  logic [31:0]  job_nonce_hi = '0;
  logic [0:255] job_target = '0;
  logic         abort = 1'b0;
  logic         msa_en;
  logic [0:511] msa_chunk;
  logic         comp_start;
  logic         comp_done = 1'b0;
  logic [0:255] comp_hash = '0;
  logic         busy;
  logic         found_valid;
  logic [31:0]  found_nonce;
  logic         exhausted;
`ifdef MINER_CTRL_STATS_EN
  logic [31:0]  hash_count;
`endif

  miner_core_ctrl #(.MSA_CYCLES(MSA), .NONCE_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_chunk    (job_chunk),
    .job_nonce_lo (job_nonce_lo),
    .job_nonce_hi (job_nonce_hi),
    .job_target   (job_target),
    .abort        (abort),
    .msa_en       (msa_en),
    .msa_chunk    (msa_chunk),
    .comp_start   (comp_start),
    .comp_done    (comp_done),
    .comp_hash    (comp_hash),
    .busy         (busy),
    .found_valid  (found_valid),
    .found_nonce  (found_nonce),
    .exhausted    (exhausted)
`ifdef MINER_CTRL_STATS_EN
    ,
    .hash_count   (hash_count)
`endif
  );

  // ---------------- clock / cycle stamp ----------------
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (or bound expired)", name);
  endtask

  // ---------------- job table ----------------
  typedef struct {
    logic [31:0]  lo;
    logic [31:0]  hi;
    logic [0:255] target;
    logic         hit_en;
    logic [31:0]  hit_nonce;
    logic [0:255] hit_hash;
    logic [0:255] miss_hash;
    int           lat;
    logic         hold;
  } vec_t;

  vec_t vecs[8];

  // Current compressor-model configuration
  logic         cur_hit_en = 1'b0;
  logic [31:0]  cur_hit_nonce = '0;
  logic [0:255] cur_hit_hash = '0;
  logic [0:255] cur_miss_hash = '0;
  int           comp_lat = 64;

  function automatic logic [0:255] hash_for(input logic [31:0] n);
    return (cur_hit_en && (n == cur_hit_nonce)) ? cur_hit_hash : cur_miss_hash;
  endfunction

  // ---------------- compressor model ----------------
  int mcnt = -1;
  always @(negedge clk) begin
    comp_done = 1'b0;
    for (int i = 0; i < 8; i++) comp_hash[i*32 +: 32] = $urandom;
    if (rst) begin
      mcnt = -1;
    end else begin
      if (comp_start) mcnt = comp_lat;
      if (mcnt == 0) begin
        comp_done = 1'b1;
        comp_hash = hash_for(msa_chunk[96:127]);
        mcnt      = -1;
      end else if (mcnt > 0) begin
        mcnt--;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0]  exp_q[$];   // expected nonce per msa_en pulse
  logic [32:0]  res_q[$];   // {found, nonce}; found=0 means exhausted
  logic [0:511] job_chunk_saved = '0;
  int           first_msa_t = -1;
  int           first_cs_t = -1;
  int           end_t = -1;
  logic         done_flag = 1'b0;

  always @(negedge clk) begin
    logic [31:0]  n;
    logic [0:511] ec;
    logic [32:0]  r;
    if (!rst) begin
      if (msa_en) begin
        if (first_msa_t < 0) first_msa_t = edge_n + 1;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_msa_en");
        end else begin
          n  = exp_q.pop_front();
          ec = job_chunk_saved;
          ec[96:127] = n;
          chk("msa_chunk", msa_chunk, ec);
        end
      end
      if (comp_start && first_cs_t < 0) first_cs_t = edge_n + 1;
      if (found_valid || exhausted) begin
        end_t     = edge_n + 1;
        done_flag = 1'b1;
        if (res_q.size() == 0) begin
          fail_now("unexpected_result_pulse");
        end else begin
          r = res_q.pop_front();
          chk("found_valid", found_valid, r[32]);
          chk("exhausted", exhausted, !r[32]);
          if (r[32]) chk("found_nonce", found_nonce, r[31:0]);
          chk("busy_at_result", busy, 1'b0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_model(input vec_t v);
    cur_hit_en    = v.hit_en;
    cur_hit_nonce = v.hit_nonce;
    cur_hit_hash  = v.hit_hash;
    cur_miss_hash = v.miss_hash;
    comp_lat      = v.lat;
  endtask

  // Walks the range the way the spec describes and fills the scoreboard.
  task automatic predict(input vec_t v, output int tries);
    logic [31:0] n;
    n = v.lo;
    tries = 0;
    for (int k = 0; k < 100; k++) begin
      exp_q.push_back(n);
      tries++;
      if (hash_for(n) < v.target) begin
        res_q.push_back({1'b1, n});
        break;
      end
      if (n == v.hi) begin
        res_q.push_back({1'b0, 32'h0});
        break;
      end
      n = n + 32'd1;
    end
  endtask

  // Offers the job for one cycle (called at posedge+1); returns acceptance edge.
  task automatic launch(input vec_t v, output int t0);
    set_model(v);
    for (int i = 0; i < 16; i++) job_chunk_saved[i*32 +: 32] = $urandom;
    done_flag    = 1'b0;
    first_msa_t  = -1;
    first_cs_t   = -1;
    end_t        = -1;
    chk("job_ready_idle", job_ready, 1'b1);
    job_chunk    = job_chunk_saved;
    job_nonce_lo = v.lo;
    job_nonce_hi = v.hi;
    job_target   = v.target;
    job_valid    = 1'b1;
    t0           = edge_n + 1;
    @(posedge clk); #1;
    if (v.hold) begin
      job_nonce_lo = v.lo + 32'd77;
      job_chunk    = ~job_chunk_saved;
      repeat (3) begin @(posedge clk); #1; end
    end
    job_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("job_ready_while_busy", job_ready, 1'b0);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int tries;
    int t0;
    int budget;
    set_model(v);
    predict(v, tries);
    launch(v, t0);
    budget = tries * (MSA + v.lat + 5) + 20;
    for (int c = 0; c < budget && !done_flag; c++) begin
      @(posedge clk); #1;
    end
    if (!done_flag) fail_now({tag, "_timeout"});
    chk({tag, "_t_msa_en"}, first_msa_t, t0 + 1);
    chk({tag, "_t_comp_start"}, first_cs_t, t0 + 2 + MSA);
    chk({tag, "_t_result"}, end_t, t0 + tries * (3 + MSA + v.lat) + 1);
    chk({tag, "_exp_q_drained"}, exp_q.size(), 0);
    chk({tag, "_res_q_drained"}, res_q.size(), 0);
`ifdef MINER_CTRL_STATS_EN
    chk({tag, "_hash_count"}, hash_count, tries);
`endif
    exp_q.delete();
    res_q.delete();
  endtask

  task automatic wait_comp_start(input string tag);
    for (int c = 0; c < 200 && !comp_start; c++) begin
      @(posedge clk); #1;
    end
    if (!comp_start) fail_now({tag, "_no_comp_start"});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [0:255] ones_v;
    logic [0:255] zero_v;
    logic [0:255] mid_v;
    logic [0:255] below_mid_v;
    vec_t         v;
    int           t0;

    ones_v      = '1;
    zero_v      = '0;
    mid_v       = '0;
    mid_v[0]    = 1'b1;
    below_mid_v = mid_v - 256'd1;

    vecs[0] = '{lo:32'd5, hi:32'd5, target:ones_v, hit_en:1'b0, hit_nonce:32'd0,
                hit_hash:zero_v, miss_hash:zero_v, lat:64, hold:1'b0};
    vecs[1] = '{lo:32'd9, hi:32'd9, target:zero_v, hit_en:1'b0, hit_nonce:32'd0,
                hit_hash:zero_v, miss_hash:zero_v, lat:64, hold:1'b0};
    vecs[2] = '{lo:32'hFFFF_FFFE, hi:32'd1, target:zero_v, hit_en:1'b0, hit_nonce:32'd0,
                hit_hash:zero_v, miss_hash:ones_v, lat:64, hold:1'b1};
    vecs[3] = '{lo:32'd0, hi:32'd10, target:mid_v, hit_en:1'b1, hit_nonce:32'd3,
                hit_hash:below_mid_v, miss_hash:mid_v, lat:64, hold:1'b0};
    vecs[4] = '{lo:32'd100, hi:32'd100, target:256'h1235, hit_en:1'b0, hit_nonce:32'd0,
                hit_hash:zero_v, miss_hash:256'h1234, lat:64, hold:1'b0};
    vecs[5] = '{lo:32'd200, hi:32'd202, target:256'h1234, hit_en:1'b0, hit_nonce:32'd0,
                hit_hash:zero_v, miss_hash:256'h1235, lat:64, hold:1'b0};
    vecs[6] = '{lo:32'd20, hi:32'd20, target:ones_v, hit_en:1'b0, hit_nonce:32'd0,
                hit_hash:zero_v, miss_hash:zero_v, lat:0, hold:1'b0};
    vecs[7] = '{lo:32'd50, hi:32'd52, target:mid_v, hit_en:1'b1, hit_nonce:32'd52,
                hit_hash:below_mid_v, miss_hash:ones_v, lat:5, hold:1'b0};

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_msa_en", msa_en, 1'b0);
    chk("rst_comp_start", comp_start, 1'b0);
    chk("rst_found_valid", found_valid, 1'b0);
    chk("rst_exhausted", exhausted, 1'b0);
    chk("rst_found_nonce", found_nonce, 32'h0);
    chk("rst_msa_chunk", msa_chunk, 512'h0);
`ifdef MINER_CTRL_STATS_EN
    chk("rst_hash_count", hash_count, 32'h0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // abort in the same cycle as job_valid blocks acceptance
    job_valid    = 1'b1;
    abort        = 1'b1;
    job_nonce_lo = 32'd1;
    job_nonce_hi = 32'd1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    abort     = 1'b0;
    chk("abort_blocks_accept_busy", busy, 1'b0);
    chk("abort_blocks_accept_msa_en", msa_en, 1'b0);
    @(posedge clk); #1;

    // Table-driven jobs
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    // Reset while in COMP (found_nonce currently 52 from the last job)
    chk("found_nonce_held", found_nonce, 32'd52);
    v = vecs[0];
    v.lo = 32'd33;
    v.hi = 32'd33;
    set_model(v);
    exp_q.push_back(32'd33);
    launch(v, t0);
    wait_comp_start("rst_in_comp");
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_comp_state_idle_ready", job_ready, 1'b1);
    chk("rst_comp_busy", busy, 1'b0);
    chk("rst_comp_msa_en", msa_en, 1'b0);
    chk("rst_comp_comp_start", comp_start, 1'b0);
    chk("rst_comp_found_valid", found_valid, 1'b0);
    chk("rst_comp_exhausted", exhausted, 1'b0);
    chk("rst_comp_found_nonce", found_nonce, 32'h0);
    chk("rst_comp_msa_chunk", msa_chunk, 512'h0);
    exp_q.delete();
    res_q.delete();
    repeat (3) begin @(posedge clk); #1; end

    // abort colliding with comp_done; nonce 7 would otherwise be a hit
    v = vecs[0];
    v.lo = 32'd7;
    v.hi = 32'd7;
    set_model(v);
    exp_q.push_back(32'd7);
    launch(v, t0);
    wait_comp_start("abort_done");
    repeat (MSA + 16 - 1) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_job_ready", job_ready, 1'b1);
    chk("abort_msa_en", msa_en, 1'b0);
    chk("abort_comp_start", comp_start, 1'b0);
    chk("abort_found_valid", found_valid, 1'b0);
`ifdef MINER_CTRL_STATS_EN
    chk("abort_hash_count", hash_count, 32'h0);
`endif
    chk("abort_exp_q_drained", exp_q.size(), 0);

    // New job immediately after abort
    v = vecs[0];
    v.lo = 32'd8;
    v.hi = 32'd8;
    run_job(v, "after_abort");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
